// File: rtl/key_int_multi.sv
// key_int_multi: NKEY-channel key interrupt controller (sync, debounce, edge select, W1C pending, mask).
// Optional build macro KEY_INT_BOTHEDGE_EN adds the per-channel BOTH register at adrs 4.
module key_int_multi #(
    parameter int NKEY   = 4,
    parameter int DB_CNT = 8,
    parameter int DB_W   = 20
) (
    input  logic            cpu_clk,
    input  logic            rst,
    input  logic            cs,
    input  logic            we,
    input  logic [15:0]     adrs,
    input  logic [15:0]     from_cpu,
    output logic [15:0]     to_cpu,
    input  logic [NKEY-1:0] key,
    output logic            int_req
);
    // state | meaning
    // IDLE  | debounced level matches synced key
    // CNT   | synced key differs from debounced level, counting toward DB_CNT
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CNT  = 2'd1
    } db_state_t;

    localparam logic [2:0]      A_PEND   = 3'd0;
    localparam logic [2:0]      A_MASK   = 3'd1;
    localparam logic [2:0]      A_EDGE   = 3'd2;
    localparam logic [2:0]      A_LEVEL  = 3'd3;
    localparam logic [2:0]      A_BOTH   = 3'd4;
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CNT - 1);

    logic [NKEY-1:0] sync_a;
    logic [NKEY-1:0] sync_s;
    logic [NKEY-1:0] stable;
    logic [NKEY-1:0] stable_d;
    logic [NKEY-1:0] rise;
    logic [NKEY-1:0] fall;
    logic [NKEY-1:0] ev;
    logic [NKEY-1:0] pend;
    logic [NKEY-1:0] mask;
    logic [NKEY-1:0] edge_sel;
    logic [NKEY-1:0] both;
    logic [NKEY-1:0] w1c;
    logic [NKEY-1:0] wdata;
    logic [NKEY-1:0] rd_sel;
    logic            wr_en;

    // keys are active-low; the synchronizer stores 1 = pressed
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_s <= '0;
        end else begin
            sync_a <= ~key;
            sync_s <= sync_a;
        end
    end

    for (genvar gi = 0; gi < NKEY; gi++) begin : g_db
        db_state_t       state;
        db_state_t       state_nxt;
        logic [DB_W-1:0] cnt;
        logic [DB_W-1:0] cnt_nxt;
        logic            stable_q;
        logic            stable_nxt;

        always_ff @(posedge cpu_clk or negedge rst) begin
            if (!rst) begin
                state    <= S_IDLE;
                cnt      <= '0;
                stable_q <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                stable_q <= stable_nxt;
            end
        end

        always_comb begin
            state_nxt  = state;
            cnt_nxt    = cnt;
            stable_nxt = stable_q;
            case (state)
                S_IDLE: begin
                    if (sync_s[gi] != stable_q) begin
                        state_nxt = S_CNT;
                        cnt_nxt   = '0;
                    end
                end
                S_CNT: begin
                    // returning to the old level before the count expires is a rejected glitch
                    if (sync_s[gi] == stable_q) begin
                        state_nxt = S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        stable_nxt = sync_s[gi];
                        state_nxt  = S_IDLE;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        assign stable[gi] = stable_q;
    end

    assign wr_en = cs & we;
    assign wdata = from_cpu[NKEY-1:0];

    always_comb begin
        rise = stable & ~stable_d;
        fall = ~stable & stable_d;
        ev   = (both & (rise | fall)) | (~both & ((edge_sel & fall) | (~edge_sel & rise)));
        w1c  = (wr_en && (adrs[2:0] == A_PEND)) ? wdata : '0;
    end

    // a new event wins over a same-cycle W1C on the same bit
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            stable_d <= '0;
            pend     <= '0;
            mask     <= '0;
            edge_sel <= '0;
            int_req  <= 1'b0;
        end else begin
            stable_d <= stable;
            pend     <= (pend & ~w1c) | ev;
            if (wr_en && (adrs[2:0] == A_MASK)) begin
                mask <= wdata;
            end
            if (wr_en && (adrs[2:0] == A_EDGE)) begin
                edge_sel <= wdata;
            end
            int_req <= |(pend & mask);
        end
    end

`ifdef KEY_INT_BOTHEDGE_EN
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            both <= '0;
        end else if (wr_en && (adrs[2:0] == A_BOTH)) begin
            both <= wdata;
        end
    end
`else
    assign both = '0;
`endif

    always_comb begin
        rd_sel = '0;
        case (adrs[2:0])
            A_PEND:  rd_sel = pend;
            A_MASK:  rd_sel = mask;
            A_EDGE:  rd_sel = edge_sel;
            A_LEVEL: rd_sel = stable;
`ifdef KEY_INT_BOTHEDGE_EN
            A_BOTH:  rd_sel = both;
`endif
            default: rd_sel = '0;
        endcase
        to_cpu = '0;
        to_cpu[NKEY-1:0] = rd_sel;
    end

    logic unused_adrs;
    assign unused_adrs = &{1'b0, adrs[15:3]};

    if (NKEY < 16) begin : g_unused_data
        logic unused_data;
        assign unused_data = &{1'b0, from_cpu[15:NKEY]};
    end

endmodule

// File: tb/tb_key_int_multi.sv
// Bench for key_int_multi: directed literal checks plus randomized keys/bus against a run-length model.
`timescale 1ns/1ps
module tb_key_int_multi;
    localparam int NKEY   = 4;
    localparam int DB_CNT = 8;

    logic            cpu_clk = 1'b0;
    logic            rst;
    logic            cs;
    logic            we;
    logic [15:0]     adrs;
    logic [15:0]     from_cpu;
    logic [15:0]     to_cpu;
    logic [NKEY-1:0] key;
    logic            int_req;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    key_int_multi #(.NKEY(NKEY), .DB_CNT(DB_CNT), .DB_W(20)) dut (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .adrs    (adrs),
        .from_cpu(from_cpu),
        .to_cpu  (to_cpu),
        .key     (key),
        .int_req (int_req)
    );

    // Reference model: a level changes once the synced key has disagreed with it
    // for DB_CNT+1 consecutive cycles; any agreeing cycle restarts that run.
    logic [NKEY-1:0] m_sa, m_sb, m_stable, m_stable_d, m_pend, m_mask, m_edge, m_both;
    logic [NKEY-1:0] t_ev;
    logic            m_int;
    int              m_run [NKEY];

    task automatic model_reset();
        m_sa = '0; m_sb = '0; m_stable = '0; m_stable_d = '0;
        m_pend = '0; m_mask = '0; m_edge = '0; m_both = '0; m_int = 1'b0;
        for (int i = 0; i < NKEY; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NKEY; i++) begin
            if (m_both[i])      t_ev[i] = (m_stable[i] != m_stable_d[i]);
            else if (m_edge[i]) t_ev[i] = !m_stable[i] && m_stable_d[i];
            else                t_ev[i] = m_stable[i] && !m_stable_d[i];
        end
        m_int = |(m_pend & m_mask);
        if (cs && we && adrs[2:0] == 3'd0) m_pend = m_pend & ~from_cpu[NKEY-1:0];
        m_pend = m_pend | t_ev;
        if (cs && we && adrs[2:0] == 3'd1) m_mask = from_cpu[NKEY-1:0];
        if (cs && we && adrs[2:0] == 3'd2) m_edge = from_cpu[NKEY-1:0];
`ifdef KEY_INT_BOTHEDGE_EN
        if (cs && we && adrs[2:0] == 3'd4) m_both = from_cpu[NKEY-1:0];
`endif
        m_stable_d = m_stable;
        for (int i = 0; i < NKEY; i++) begin
            if (m_sb[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DB_CNT + 1) begin
                    m_stable[i] = m_sb[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_sb = m_sa;
        m_sa = ~key;
    endtask

    initial begin
        forever begin
            @(posedge cpu_clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        logic [15:0] r = '0;
        case (a)
            3'd0: r[NKEY-1:0] = m_pend;
            3'd1: r[NKEY-1:0] = m_mask;
            3'd2: r[NKEY-1:0] = m_edge;
            3'd3: r[NKEY-1:0] = m_stable;
            3'd4: r[NKEY-1:0] = m_both;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge cpu_clk) begin
        if (chk_en) begin
            check("cyc_int_req", {15'h0, int_req}, {15'h0, m_int});
            check("cyc_to_cpu", to_cpu, exp_rd(adrs[2:0]));
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cs = 1'b1; we = 1'b1; adrs = {13'h0, a}; from_cpu = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic expect_rd(input string nm, input logic [2:0] a, input logic [15:0] e);
        adrs = {13'h0, a};
        #1;
        check(nm, to_cpu, e);
    endtask

    task automatic expect_int(input string nm, input logic e);
        check(nm, {15'h0, int_req}, {15'h0, e});
    endtask

    int hold [NKEY];
    int r;

    initial begin
        rst = 1'b0; key = '1; cs = 1'b0; we = 1'b0; adrs = '0; from_cpu = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        for (int a = 0; a < 8; a++) begin
            expect_rd("reset_reg", a[2:0], 16'h0000);
            tick();
        end
        expect_int("reset_int", 1'b0);
        rst = 1'b1;
        tick();

        // press key0 with MASK=1; the write edge is edge 0
        wr(3'd1, 16'h0001);
        key[0] = 1'b0;
        repeat (10) tick();
        expect_rd("lvl_edge10", 3'd3, 16'h0000);
        tick();
        expect_rd("lvl_edge11", 3'd3, 16'h0001);
        expect_rd("pend_edge11", 3'd0, 16'h0000);
        tick();
        expect_rd("pend_edge12", 3'd0, 16'h0001);
        expect_int("int_edge12", 1'b0);
        tick();
        expect_int("int_edge13", 1'b1);

        wr(3'd0, 16'h0001);
        expect_rd("w1c_pend", 3'd0, 16'h0000);
        expect_int("w1c_int_hold", 1'b1);
        tick();
        expect_int("w1c_int_drop", 1'b0);

        key[1] = 1'b0;
        repeat (5) tick();
        key[1] = 1'b1;
        repeat (20) tick();
        expect_rd("glitch_lvl", 3'd3, 16'h0001);
        expect_rd("glitch_pend", 3'd0, 16'h0000);
        expect_int("glitch_int", 1'b0);

        key[0] = 1'b1;
        repeat (20) tick();
        expect_rd("release_no_ev", 3'd0, 16'h0000);
        key[0] = 1'b0;
        repeat (11) tick();
        wr(3'd0, 16'h0001);
        expect_rd("set_beats_w1c", 3'd0, 16'h0001);
        wr(3'd0, 16'h0001);
        expect_rd("w1c_again", 3'd0, 16'h0000);

        wr(3'd2, 16'h0004);
        key[2] = 1'b0;
        repeat (15) tick();
        expect_rd("edge_press_pend", 3'd0, 16'h0000);
        expect_rd("edge_press_lvl", 3'd3, 16'h0005);
        key[2] = 1'b1;
        repeat (11) tick();
        expect_rd("edge_rel_11", 3'd0, 16'h0000);
        tick();
        expect_rd("edge_rel_12", 3'd0, 16'h0004);

        wr(3'd0, 16'h0004);
        wr(3'd1, 16'h0000);
        key[3] = 1'b0;
        repeat (14) tick();
        expect_rd("mask0_pend", 3'd0, 16'h0008);
        expect_int("mask0_int", 1'b0);
        wr(3'd1, 16'h0008);
        expect_int("remask_edge1", 1'b0);
        tick();
        expect_int("remask_edge2", 1'b1);

`ifdef KEY_INT_BOTHEDGE_EN
        wr(3'd0, 16'h0008);
        wr(3'd4, 16'h0001);
        expect_rd("both_rd", 3'd4, 16'h0001);
        key[0] = 1'b1;
        repeat (14) tick();
        expect_rd("both_release", 3'd0, 16'h0001);
        wr(3'd0, 16'h0001);
        key[0] = 1'b0;
        repeat (14) tick();
        expect_rd("both_press", 3'd0, 16'h0001);
        wr(3'd0, 16'h0001);
`else
        wr(3'd4, 16'hFFFF);
        expect_rd("both_absent", 3'd4, 16'h0000);
`endif

        // reset while key1 is mid-debounce; held keys 0,1,3 must re-debounce afterwards
        key[1] = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        expect_int("rst_int", 1'b0);
        expect_rd("rst_pend", 3'd0, 16'h0000);
        expect_rd("rst_lvl", 3'd3, 16'h0000);
        tick();
        expect_rd("rst_mask", 3'd1, 16'h0000);
        expect_rd("rst_edge", 3'd2, 16'h0000);
        rst = 1'b1;
        repeat (14) tick();
        expect_rd("rerun_lvl", 3'd3, 16'h000B);
        expect_rd("rerun_pend", 3'd0, 16'h000B);
        expect_int("rerun_int", 1'b0);

        for (int i = 0; i < NKEY; i++) hold[i] = $urandom_range(1, 16);
        repeat (4000) begin
            for (int i = 0; i < NKEY; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    key[i] = ~key[i];
                    hold[i] = $urandom_range(1, 16);
                end
            end
            r = $urandom_range(0, 99);
            if (r < 20)      begin cs = 1'b1; we = 1'b1; end
            else if (r < 30) begin cs = 1'b1; we = 1'b0; end
            else if (r < 35) begin cs = 1'b0; we = 1'b1; end
            else             begin cs = 1'b0; we = 1'b0; end
            adrs     = 16'($urandom);
            from_cpu = 16'($urandom);
            rst      = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        cs = 1'b0; we = 1'b0; rst = 1'b1;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
